// File: rtl/dds_wave_gen.sv
// DDS waveform source: divided-tick phase accumulator, wave shaping and
// signed amplitude scaling into a registered PCM sample for the 1-bit DAC.
module dds_wave_gen #(
    parameter int PW  = 30,
    parameter int W   = 16,
    parameter int DIV = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          load,
    input  logic [PW-1:0] fccw,
    input  logic [PW-1:0] pha,
    input  logic [W-1:0]  amp,
    input  logic [1:0]    wave,
    output logic [W-1:0]  pcm_out,
    output logic          pcm_valid,
    output logic          wrap
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [W-1:0] POS_FS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] NEG_FS = {1'b1, {(W-2){1'b0}}, 1'b1};
    localparam logic [W-1:0] MIN_V  = {1'b1, {(W-1){1'b0}}};

    logic [CW-1:0] div_cnt;
    logic          tick;
    logic [PW-1:0] p_reg;
    logic [PW-1:0] stg_fccw, stg_pha, act_fccw, act_pha;
    logic [W-1:0]  stg_amp, act_amp;
    logic [1:0]    stg_wave, act_wave;
    logic [PW:0]   p_sum;
    logic [PW-1:0] s_phase;
    logic [W-1:0]  u;
    logic [W-2:0]  tri_t;
    logic [W-1:0]  raw;
    logic          s1_valid;
    logic [W-1:0]  s1_raw, s1_amp;
    logic signed [2*W-1:0] prod;
    logic [W-1:0]  scaled;

    assign tick    = en && (div_cnt == CNT_MAX);
    assign p_sum   = {1'b0, p_reg} + {1'b0, act_fccw};
    assign s_phase = p_reg + act_pha;
    assign u       = W'(s_phase >> (PW - W));
    assign tri_t   = u[W-1] ? ~u[W-2:0] : u[W-2:0];

    always_comb begin
        raw = '0;
        unique case (act_wave)
            2'b00:   raw = {~u[W-1], u[W-2:0]};
            2'b01:   raw = u[W-1] ? NEG_FS : POS_FS;
            2'b10:   raw = {~tri_t[W-2], tri_t[W-3:0], 1'b0};
            default: raw = POS_FS;
        endcase
    end

    // -1 * -1 is the only product that does not fit after the shift
    assign prod   = $signed(s1_raw) * $signed(s1_amp);
    assign scaled = (s1_raw == MIN_V && s1_amp == MIN_V) ? POS_FS
                  : W'(prod >>> (W - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            p_reg   <= '0;
            wrap    <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (en)
                div_cnt <= (div_cnt == CNT_MAX) ? '0 : div_cnt + CW'(1);
            if (tick) begin
                p_reg <= p_sum[PW-1:0];
                wrap  <= p_sum[PW];
            end
        end
    end

    // staging -> active only on ticks, so a load never lands mid-sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg_fccw <= '0;
            stg_pha  <= '0;
            stg_amp  <= '0;
            stg_wave <= '0;
            act_fccw <= '0;
            act_pha  <= '0;
            act_amp  <= '0;
            act_wave <= '0;
        end else begin
            if (load) begin
                stg_fccw <= fccw;
                stg_pha  <= pha;
                stg_amp  <= amp;
                stg_wave <= wave;
            end
            if (tick) begin
                act_fccw <= stg_fccw;
                act_pha  <= stg_pha;
                act_amp  <= stg_amp;
                act_wave <= stg_wave;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_raw    <= '0;
            s1_amp    <= '0;
            pcm_valid <= 1'b0;
            pcm_out   <= '0;
        end else begin
            s1_valid  <= tick;
            pcm_valid <= s1_valid;
            if (tick) begin
                s1_raw <= raw;
                s1_amp <= act_amp;
            end
            if (s1_valid)
                pcm_out <= scaled;
        end
    end

endmodule

// File: tb/tb_dds_wave_gen.sv
// Bench for dds_wave_gen: behavioural model feeds a scoreboard queue,
// plus directed checks of latency, wrap, saturation and reset/en corners.
module tb_dds_wave_gen;

    localparam int PW  = 16;
    localparam int W   = 16;
    localparam int DIV = 4;
    localparam longint HALF = 64'd1 << (W - 1);
    localparam longint PMOD = 64'd1 << PW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          load = 1'b0;
    logic [PW-1:0] fccw = '0;
    logic [PW-1:0] pha = '0;
    logic [W-1:0]  amp = '0;
    logic [1:0]    wave = '0;
    logic [W-1:0]  pcm_out;
    logic          pcm_valid;
    logic          wrap;

    int n_checks = 0;
    int n_fail = 0;
    int nvalid = 0;
    int wrap_cnt = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    logic [W-1:0] last_exp = '0;
    bit m_wrap = 1'b0;

    longint m_cnt = 0, m_p = 0;
    longint s_f = 0, s_p = 0, s_a = 0, s_w = 0;
    longint a_f = 0, a_p = 0, a_a = 0, a_w = 0;

    dds_wave_gen #(.PW(PW), .W(W), .DIV(DIV)) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .load(load),
        .fccw(fccw),
        .pha(pha),
        .amp(amp),
        .wave(wave),
        .pcm_out(pcm_out),
        .pcm_valid(pcm_valid),
        .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [W-1:0] model_sample(longint p, longint ph_off,
                                                  longint a, longint w);
        longint ph, uu, t, r, sa, prd, q;
        logic [63:0] qb;
        ph = (p + ph_off) % PMOD;
        uu = ph >> (PW - W);
        case (w)
            0: r = uu - HALF;
            1: r = (uu < HALF) ? HALF - 1 : -(HALF - 1);
            2: begin
                t = (uu < HALF) ? uu : (HALF - 1) - (uu - HALF);
                r = 2 * t - HALF;
            end
            default: r = HALF - 1;
        endcase
        sa = (a >= HALF) ? a - 2 * HALF : a;
        prd = r * sa;
        q = prd / HALF;
        if (prd < 0 && q * HALF != prd) q = q - 1;
        if (q > HALF - 1) q = HALF - 1;
        qb = q;
        return qb[W-1:0];
    endfunction

    // reference model: tick, staging/active and phase at each clock edge
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_cnt = 0; m_p = 0; m_wrap = 1'b0;
                s_f = 0; s_p = 0; s_a = 0; s_w = 0;
                a_f = 0; a_p = 0; a_a = 0; a_w = 0;
                exp_q.delete();
            end else begin
                m_wrap = 1'b0;
                if (en && m_cnt == DIV - 1) begin
                    exp_q.push_back(model_sample(m_p, a_p, a_a, a_w));
                    m_wrap = (m_p + a_f) >= PMOD;
                    m_p = (m_p + a_f) % PMOD;
                    a_f = s_f; a_p = s_p; a_a = s_a; a_w = s_w;
                end
                if (en) m_cnt = (m_cnt == DIV - 1) ? 0 : m_cnt + 1;
                if (load) begin
                    s_f = fccw; s_p = pha; s_a = amp; s_w = wave;
                end
            end
        end
    end

    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                last_exp = '0;
            end else begin
                if (pcm_valid) begin
                    nvalid++;
                    got_q.push_back(pcm_out);
                    if (exp_q.size() == 0) begin
                        check("spurious_valid", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_pcm", pcm_out, e);
                        last_exp = e;
                    end
                end else begin
                    check("pcm_hold", pcm_out, last_exp);
                end
                check("wrap", wrap, m_wrap);
                if (wrap) wrap_cnt++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int lim, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!pcm_valid && n < lim);
    endtask

    task automatic load_and_run(input logic [PW-1:0] f, input logic [PW-1:0] p,
                                input logic [W-1:0] a, input logic [1:0] w,
                                input int cyc);
        fccw = f; pha = p; amp = a; wave = w;
        load = 1'b1;
        step(1);
        load = 1'b0;
        step(cyc - 1);
    endtask

    initial begin
        int n, k, nv0;
        step(3);
        check("rst_pcm", pcm_out, 0);
        check("rst_valid", pcm_valid, 0);
        check("rst_wrap", wrap, 0);
        reset = 1'b0;
        step(1);

        en = 1'b1;
        wait_valid(10, n);
        check("first_valid_lat", n, 5);
        wait_valid(10, n);
        check("valid_period", n, 4);
        check("zero_pcm", pcm_out, 0);

        got_q.delete();
        wrap_cnt = 0;
        load_and_run(16'h1000, 16'h0000, 16'h7FFF, 2'b00, 80);
        k = -1;
        foreach (got_q[i])
            if (k < 0 && got_q[i] != 0) k = i;
        if (k >= 1 && k + 2 < got_q.size()) begin
            check("saw_s0", got_q[k], 16'h8001);
            check("saw_s1", got_q[k+1], 16'h9000);
            check("saw_s2", got_q[k+2], 16'hA000);
        end else begin
            check("saw_seq_found", 0, 1);
        end
        check("wrap_once", wrap_cnt, 1);

        reset = 1'b1;
        en = 1'b0;
        step(2);
        reset = 1'b0;
        en = 1'b1;
        load_and_run(16'h0000, 16'h0000, 16'h8000, 2'b00, 16);
        check("sat_pcm", pcm_out, 16'h7FFF);
        load_and_run(16'h0000, 16'h0000, 16'h4000, 2'b01, 14);
        check("sq_pos", pcm_out, 16'h3FFF);
        load_and_run(16'h0000, 16'h8000, 16'h4000, 2'b01, 14);
        check("sq_neg", pcm_out, 16'hC000);
        load_and_run(16'h0000, 16'h4000, 16'h7FFF, 2'b10, 14);
        check("tri_mid", pcm_out, 16'h0000);
        load_and_run(16'h0000, 16'h0000, 16'h7FFF, 2'b10, 14);
        check("tri_low", pcm_out, 16'h8001);
        load_and_run(16'h0000, 16'h0000, 16'hC000, 2'b11, 14);
        check("dc_neg", pcm_out, 16'hC000);

        load_and_run(16'h1000, 16'h0000, 16'h7FFF, 2'b00, 16);
        wait_valid(8, n);
        step(2);
        fccw = 16'h3000;
        load = 1'b1;
        step(1);
        load = 1'b0;
        step(40);

        wait_valid(8, n);
        step(3);
        reset = 1'b1;
        #1;
        check("arst_pcm", pcm_out, 0);
        check("arst_valid", pcm_valid, 0);
        check("arst_wrap", wrap, 0);
        step(2);
        reset = 1'b0;
        wait_valid(10, n);
        check("restart_lat", n, 5);
        check("restart_pcm", pcm_out, 0);

        load_and_run(16'h1000, 16'h0000, 16'h7FFF, 2'b00, 20);
        wait_valid(8, n);
        step(3);
        en = 1'b0;
        wait_valid(4, n);
        check("inflight_lat", n, 1);
        step(1);
        nv0 = nvalid;
        step(20);
        check("en_off_no_valid", nvalid - nv0, 0);
        check("en_off_hold", pcm_out, last_exp);
        en = 1'b1;
        step(24);
        en = 1'b0;
        step(6);
        check("sb_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
